// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the IF/MEM memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W_DEF  = 32;
   localparam int unsigned DATA_W_DEF  = 32;
   localparam int unsigned TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_D_BUSY  = 2'd1,
      ST_IF_BUSY = 2'd2
   } arb_state_e;

endpackage

// File: rtl/arb_timeout_counter.sv
// Watchdog counter: expired_o is high during the TERM-th consecutive enabled
// cycle since the last clear.
module arb_timeout_counter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TERM = TIMEOUT_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = (TERM > 1) ? $clog2(TERM) : 1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             expired_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      expired_d = (cnt_d == CNT_W'(TERM - 1));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q     <= '0;
         expired_o <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_o <= expired_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access,
// data first, with flush-kill of in-flight fetches and a transaction watchdog.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W  = ADDR_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_valid_o,
   input  logic              flush_i,
   input  logic              d_req_i,
   input  logic              d_we_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [DATA_W-1:0] d_wdata_i,
   output logic [DATA_W-1:0] d_rdata_o,
   output logic              d_valid_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_o,
   output logic              err_o
);

   arb_state_e state_q;
   logic       kill_q;

   logic d_req_m_c;
   logic if_req_m_c;
   logic fetch_killed_c;
   logic busy_c;
   logic done_c;
   logic wd_clear_c;
   logic wd_enable_c;
   logic wd_expired;

   // A requester's req is ignored in its own valid cycle.
   assign d_req_m_c      = d_req_i & ~d_valid_o;
   assign if_req_m_c     = if_req_i & ~if_valid_o;
   assign fetch_killed_c = kill_q | flush_i;
   assign busy_c         = (state_q != ST_IDLE);
   assign done_c         = mem_ack_i | wd_expired;

   assign wd_clear_c  = ~busy_c;
   assign wd_enable_c = busy_c & ~mem_ack_i;

   assign stall_o = (if_req_i & ~if_valid_o & ~flush_i) | (d_req_i & ~d_valid_o);

   generate
      if (TIMEOUT != 0) begin : g_wdog
         arb_timeout_counter #(
            .TERM (TIMEOUT)
         ) u_wdog (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .clear_i   (wd_clear_c),
            .enable_i  (wd_enable_c),
            .expired_o (wd_expired)
         );
      end else begin : g_no_wdog
         assign wd_expired = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         kill_q      <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         if_rdata_o  <= '0;
         if_valid_o  <= 1'b0;
         d_rdata_o   <= '0;
         d_valid_o   <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         if_valid_o <= 1'b0;
         d_valid_o  <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               kill_q <= 1'b0;
               if (d_req_m_c) begin
                  state_q     <= ST_D_BUSY;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= d_we_i;
                  mem_addr_o  <= d_addr_i;
                  mem_wdata_o <= d_we_i ? d_wdata_i : '0;
               end else if (if_req_m_c) begin
                  state_q     <= ST_IF_BUSY;
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= 1'b0;
                  mem_addr_o  <= if_addr_i;
                  mem_wdata_o <= '0;
               end
            end
            ST_D_BUSY: begin
               if (done_c) begin
                  state_q   <= ST_IDLE;
                  mem_req_o <= 1'b0;
                  d_valid_o <= 1'b1;
                  d_rdata_o <= (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
                  if (!mem_ack_i) begin
                     err_o <= 1'b1;
                  end
               end
            end
            ST_IF_BUSY: begin
               // A flush in the completing cycle still suppresses the result.
               if (done_c) begin
                  state_q   <= ST_IDLE;
                  mem_req_o <= 1'b0;
                  if (!fetch_killed_c) begin
                     if_valid_o <= 1'b1;
                     if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                  end
                  if (!mem_ack_i) begin
                     err_o <= 1'b1;
                  end
               end else begin
                  kill_q <= fetch_killed_c;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               mem_req_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a memory/arbitration
// reference model, plus reset and mid-transaction reset scenarios.
module tb_mem_port_arbiter;

   localparam int unsigned AW       = 32;
   localparam int unsigned DW       = 32;
   localparam int unsigned TO       = 4;
   localparam int unsigned N_TXN    = 60;
   localparam int unsigned WAIT_MAX = 400;

   logic          clk_i       = 1'b0;
   logic          rst_i       = 1'b1;
   logic          if_req_i    = 1'b0;
   logic [AW-1:0] if_addr_i   = '0;
   logic [DW-1:0] if_rdata_o;
   logic          if_valid_o;
   logic          flush_i     = 1'b0;
   logic          d_req_i     = 1'b0;
   logic          d_we_i      = 1'b0;
   logic [AW-1:0] d_addr_i    = '0;
   logic [DW-1:0] d_wdata_i   = '0;
   logic [DW-1:0] d_rdata_o;
   logic          d_valid_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_ack_i   = 1'b0;
   logic [DW-1:0] mem_rdata_i = '0;
   logic          stall_o;
   logic          err_o;

   mem_port_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TO)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .if_req_i    (if_req_i),
      .if_addr_i   (if_addr_i),
      .if_rdata_o  (if_rdata_o),
      .if_valid_o  (if_valid_o),
      .flush_i     (flush_i),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_rdata_o   (d_rdata_o),
      .d_valid_o   (d_valid_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ack_i   (mem_ack_i),
      .mem_rdata_i (mem_rdata_i),
      .stall_o     (stall_o),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h, expected 0x%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t d_q[$];
   exp_t if_q[$];

   // Unified memory image; unwritten words read as an address-derived pattern.
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
   endfunction

   bit resp_en   = 1'b1;
   bit stray_ack = 1'b0;
   bit run_flush = 1'b0;

   // Memory responder and bus-protocol model.
   bit          r_active = 0, r_is_d = 0, r_we = 0, r_kill = 0, r_expect_low = 0;
   bit          r_err_exp = 0, r_err_pend = 0, r_rst_prev = 1;
   bit          r_prev_req = 1, r_prev_dpend = 0, r_prev_ipend = 0, r_prev_dwe = 0;
   logic [31:0] r_prev_daddr = 0, r_prev_dwdata = 0, r_prev_iaddr = 0;
   logic [31:0] r_addr = 0, r_wdata = 0, r_rd = 0;
   int          r_n = 0, r_k = 0;

   initial begin : responder
      forever begin
         @(negedge clk_i);
         mem_ack_i   = 1'b0;
         mem_rdata_i = $urandom;
         if (r_rst_prev) begin
            r_err_exp  = 0;
            r_err_pend = 0;
         end else if (r_err_pend) begin
            r_err_exp  = 1;
            r_err_pend = 0;
         end
         if (rst_i || !resp_en) begin
            r_active     = 0;
            r_expect_low = 0;
            r_prev_req   = 1;
            r_prev_dpend = 0;
            r_prev_ipend = 0;
            mem_ack_i    = stray_ack;
            r_rst_prev   = rst_i;
         end else begin
            chk("err_o", 32'(err_o), 32'(r_err_exp));
            if (r_expect_low) begin
               chk("req_drop", 32'(mem_req_o), 32'h0);
               r_expect_low = 0;
            end else if (!r_prev_req) begin
               chk("grant", 32'(mem_req_o), 32'(r_prev_dpend | r_prev_ipend));
               if (mem_req_o) begin
                  r_active = 1;
                  r_n      = 0;
                  r_kill   = 0;
                  r_is_d   = r_prev_dpend;
                  r_we     = r_is_d ? r_prev_dwe : 1'b0;
                  r_addr   = r_is_d ? r_prev_daddr : r_prev_iaddr;
                  r_wdata  = (r_is_d && r_prev_dwe) ? r_prev_dwdata : 32'h0;
                  r_k      = $urandom_range(1, TO + 2);
               end
            end
            if (r_active) begin
               r_n++;
               chk("bus_req", 32'(mem_req_o), 32'h1);
               chk("bus_we", 32'(mem_we_o), 32'(r_we));
               chk("bus_addr", mem_addr_o, r_addr);
               chk("bus_wdata", mem_wdata_o, r_wdata);
               if (!r_is_d && flush_i) r_kill = 1;
               if (r_n == r_k) begin
                  mem_ack_i = 1'b1;
                  r_rd      = mem_rd(r_addr);
                  if (r_is_d && r_we) begin
                     mem[r_addr] = r_wdata;
                     d_q.push_back('{data: 32'h0, cyc: cyc + 1});
                  end else begin
                     mem_rdata_i = r_rd;
                     if (r_is_d) d_q.push_back('{data: r_rd, cyc: cyc + 1});
                     else if (!r_kill) if_q.push_back('{data: r_rd, cyc: cyc + 1});
                  end
                  r_active     = 0;
                  r_expect_low = 1;
               end else if (r_n == TO) begin
                  r_err_pend = 1;
                  if (r_is_d) d_q.push_back('{data: 32'h0, cyc: cyc + 1});
                  else if (!r_kill) if_q.push_back('{data: 32'h0, cyc: cyc + 1});
                  r_active     = 0;
                  r_expect_low = 1;
               end
            end else if (!r_expect_low && $urandom_range(0, 7) == 0) begin
               mem_ack_i = 1'b1;  // spurious ack while idle
            end
            r_prev_req    = mem_req_o;
            r_prev_dpend  = d_req_i & ~d_valid_o;
            r_prev_ipend  = if_req_i & ~if_valid_o;
            r_prev_dwe    = d_we_i;
            r_prev_daddr  = d_addr_i;
            r_prev_dwdata = d_wdata_i;
            r_prev_iaddr  = if_addr_i;
            r_rst_prev    = 0;
         end
      end
   end

   // Output monitor: pops expectations on each valid pulse.
   bit          m_rst_prev = 1;
   logic [31:0] m_d_last = 0, m_if_last = 0;
   exp_t        m_e;

   initial begin : monitor
      forever begin
         @(negedge clk_i);
         if (m_rst_prev) begin
            m_d_last  = 0;
            m_if_last = 0;
            d_q.delete();
            if_q.delete();
         end
         if (d_valid_o) begin
            if (d_q.size() == 0) begin
               chk("d_valid_unexpected", 32'(d_valid_o), 32'h0);
            end else begin
               m_e = d_q.pop_front();
               chk("d_rdata", d_rdata_o, m_e.data);
               chk("d_latency", 32'(cyc), 32'(m_e.cyc));
               m_d_last = m_e.data;
            end
         end else begin
            chk("d_rdata_hold", d_rdata_o, m_d_last);
         end
         if (if_valid_o) begin
            if (if_q.size() == 0) begin
               chk("if_valid_unexpected", 32'(if_valid_o), 32'h0);
            end else begin
               m_e = if_q.pop_front();
               chk("if_rdata", if_rdata_o, m_e.data);
               chk("if_latency", 32'(cyc), 32'(m_e.cyc));
               m_if_last = m_e.data;
            end
         end else begin
            chk("if_rdata_hold", if_rdata_o, m_if_last);
         end
         chk("stall", 32'(stall_o),
             32'((if_req_i & ~if_valid_o & ~flush_i) | (d_req_i & ~d_valid_o)));
         m_rst_prev = rst_i;
      end
   end

   initial begin : flusher
      forever begin
         @(posedge clk_i);
         #1;
         flush_i = run_flush && ($urandom_range(0, 5) == 0);
      end
   end

   task automatic d_driver();
      for (int i = 0; i < int'(N_TXN); i++) begin
         int w;
         @(posedge clk_i);
         #1;
         if ($urandom_range(0, 2) == 0) begin
            d_req_i = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk_i);
            #1;
         end
         d_req_i   = 1'b1;
         d_we_i    = 1'($urandom_range(0, 1));
         d_addr_i  = 32'($urandom_range(0, 15)) << 2;
         d_wdata_i = $urandom;
         w = 0;
         do begin
            @(negedge clk_i);
            w++;
         end while (!d_valid_o && w < int'(WAIT_MAX));
         chk("d_done", 32'(d_valid_o), 32'h1);
      end
      @(posedge clk_i);
      #1 d_req_i = 1'b0;
   endtask

   task automatic if_driver();
      for (int i = 0; i < int'(N_TXN); i++) begin
         int w;
         @(posedge clk_i);
         #1;
         if ($urandom_range(0, 2) == 0) begin
            if_req_i = 1'b0;
            repeat ($urandom_range(1, 4)) @(posedge clk_i);
            #1;
         end
         if_req_i  = 1'b1;
         if_addr_i = 32'($urandom_range(0, 15)) << 2;
         w = 0;
         do begin
            @(negedge clk_i);
            w++;
         end while (!if_valid_o && w < int'(WAIT_MAX));
         chk("if_done", 32'(if_valid_o), 32'h1);
      end
      @(posedge clk_i);
      #1 if_req_i = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL global_timeout: simulation exceeded its time budget");
      $fatal(1, "bench timeout");
   end

   bit seen;

   initial begin : main
      rst_i = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_mem_req", 32'(mem_req_o), 32'h0);
      chk("rst_mem_we", 32'(mem_we_o), 32'h0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_mem_wdata", mem_wdata_o, 32'h0);
      chk("rst_if_valid", 32'(if_valid_o), 32'h0);
      chk("rst_if_rdata", if_rdata_o, 32'h0);
      chk("rst_d_valid", 32'(d_valid_o), 32'h0);
      chk("rst_d_rdata", d_rdata_o, 32'h0);
      chk("rst_err", 32'(err_o), 32'h0);
      chk("rst_stall", 32'(stall_o), 32'h0);

      @(posedge clk_i);
      #1 rst_i = 1'b0;
      run_flush = 1'b1;
      fork
         d_driver();
         if_driver();
      join
      run_flush = 1'b0;
      repeat (12) @(negedge clk_i);
      chk("d_q_drain", 32'(d_q.size()), 32'h0);
      chk("if_q_drain", 32'(if_q.size()), 32'h0);

      // Reset in the middle of a data transaction, then a stray ack.
      @(posedge clk_i);
      #1;
      resp_en  = 1'b0;
      d_req_i  = 1'b1;
      d_we_i   = 1'b0;
      d_addr_i = 32'h100;
      seen     = 1'b0;
      for (int w = 0; w < 20 && !seen; w++) begin
         @(negedge clk_i);
         seen = mem_req_o;
      end
      chk("mid_grant", 32'(seen), 32'h1);
      chk("mid_addr", mem_addr_o, 32'h100);
      @(posedge clk_i);
      #1;
      rst_i   = 1'b1;
      d_req_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      chk("mid_rst_mem_req", 32'(mem_req_o), 32'h0);
      chk("mid_rst_mem_addr", mem_addr_o, 32'h0);
      chk("mid_rst_d_valid", 32'(d_valid_o), 32'h0);
      chk("mid_rst_d_rdata", d_rdata_o, 32'h0);
      chk("mid_rst_err", 32'(err_o), 32'h0);
      @(posedge clk_i);
      #1;
      rst_i     = 1'b0;
      stray_ack = 1'b1;
      @(posedge clk_i);
      #1 stray_ack = 1'b0;
      repeat (3) begin
         @(negedge clk_i);
         chk("stray_d_valid", 32'(d_valid_o), 32'h0);
         chk("stray_if_valid", 32'(if_valid_o), 32'h0);
         chk("stray_mem_req", 32'(mem_req_o), 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
